cmu_phase_seq: RTL and testbench

Parametrised clock-management phase sequencer. It generates NPHASE non-overlapping, one-clock phase-enable pulses per machine cycle, with a run-time programmable slot length. It sits at the top of the core clock tree and supplies the phase enables to every pipeline stage. Compared with the fixed two-phase divider, it adds:
- a masked multi-source stall that freezes the sequencer at machine-cycle boundaries instead of dropping phases;
- an optional single-step mode.

---
 rtl/cmu_phase_seq.sv | 136 +++++++++++++
 tb/tb_cmu_phase_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmu_phase_seq.sv
// cmu_phase_seq: NPHASE one-hot phase enables per machine cycle, slot = div_i+2 clocks; single-step logic under `CMU_STEP_EN.
// Latency: cycle_start_o one clock after go in IDLE; stalls and steps are honoured only at machine-cycle boundaries.
module cmu_phase_seq #(
  parameter int NPHASE = 2,
  parameter int DIV_W  = 4,
  parameter int NSTALL = 2
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic [NSTALL-1:0] stall_i,
  input  logic [NSTALL-1:0] stall_mask_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              step_mode_i,
  input  logic              step_req_i,
  output logic [NPHASE-1:0] phi_o,
  output logic              cycle_start_o,
  output logic              stalled_o,
  output logic              step_ack_o,
  output logic              clk_o,
  output logic              clear_o
);

  localparam int PW = (NPHASE > 1) ? $clog2(NPHASE) : 1;
  localparam logic [DIV_W:0]    SLOT_ONE = {{DIV_W{1'b0}}, 1'b1};
  localparam logic [PW-1:0]     PH_ONE   = PW'(1);
  localparam logic [PW-1:0]     PH_LAST  = PW'(NPHASE - 1);
  localparam logic [NPHASE-1:0] PHI_LSB  = NPHASE'(1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [DIV_W:0]    slot_q, slot_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              stall_act;
  logic              go;
  logic              slot_end;
  logic              start_c;

  assign stall_act = |(stall_i & ~stall_mask_i);
  assign slot_end  = (state_q == ST_RUN) && (slot_q == ({1'b0, div_q} + SLOT_ONE));

`ifdef CMU_STEP_EN
  logic step_pend_q, step_pend_d;
  logic step_cyc_q, step_cyc_d;

  assign go = !stall_act && (!step_mode_i || step_pend_q);
`else
  logic unused_step_in;

  assign unused_step_in = step_mode_i | step_req_i;
  assign go = !stall_act;
`endif

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    phase_d = phase_q;
    div_d   = div_q;
    start_c = 1'b0;
`ifdef CMU_STEP_EN
    step_pend_d = step_pend_q;
    step_cyc_d  = step_cyc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (go) start_c = 1'b1;
      end
      ST_RUN: begin
        slot_d = slot_q + SLOT_ONE;
        if (slot_end) begin
          slot_d  = '0;
          phase_d = phase_q + PH_ONE;
          // Final slot of the last phase: restart back-to-back or park in IDLE.
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            if (go) start_c = 1'b1;
            else    state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_c) begin
      state_d = ST_RUN;
      slot_d  = '0;
      phase_d = '0;
      div_d   = div_i;
`ifdef CMU_STEP_EN
      step_cyc_d = step_mode_i;
      if (step_mode_i) step_pend_d = 1'b0;
`endif
    end
`ifdef CMU_STEP_EN
    // A new request wins over consumption; a request while pending is simply absorbed.
    if (step_req_i) step_pend_d = 1'b1;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      phase_q <= '0;
      div_q   <= '0;
`ifdef CMU_STEP_EN
      step_pend_q <= 1'b0;
      step_cyc_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      phase_q <= phase_d;
      div_q   <= div_d;
`ifdef CMU_STEP_EN
      step_pend_q <= step_pend_d;
      step_cyc_q  <= step_cyc_d;
`endif
    end
  end

  assign phi_o         = (slot_end && !clear_i) ? (PHI_LSB << phase_q) : '0;
  assign cycle_start_o = (state_q == ST_RUN) && (slot_q == '0) && (phase_q == '0) && !clear_i;
  assign stalled_o     = (state_q == ST_IDLE) && stall_act;

`ifdef CMU_STEP_EN
  assign step_ack_o = step_cyc_q && phi_o[NPHASE-1];
`else
  assign step_ack_o = 1'b0;
`endif

  assign clk_o   = clk_i;
  assign clear_o = clear_i;

endmodule

// File: tb/tb_cmu_phase_seq.sv
// Bench for cmu_phase_seq: a two-phase and a four-phase instance, expected phase events queued ahead of time.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_cmu_phase_seq;

  typedef struct {
    int         cyc;
    logic [3:0] phi;
    logic       cs;
    logic       ack;
  } evt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  bit done  = 1'b0;

  evt_t qa[$];
  evt_t qb[$];

  // Two-phase instance
  logic       clear_a = 1'b1;
  logic [1:0] stall_a = '0, mask_a = '0;
  logic [3:0] div_a = '0;
  logic       step_mode_a = 1'b0, step_req_a = 1'b0;
  logic [1:0] phi_a;
  logic       cs_a, stalled_a, ack_a, clk_oa, clear_oa;

  // Four-phase instance
  logic       clear_b = 1'b1;
  logic [1:0] stall_b = '0, mask_b = '0;
  logic [3:0] div_b = '0;
  logic       step_mode_b = 1'b0, step_req_b = 1'b0;
  logic [3:0] phi_b;
  logic       cs_b, stalled_b, ack_b, clk_ob, clear_ob;

  cmu_phase_seq #(.NPHASE(2), .DIV_W(4), .NSTALL(2)) u_dut_a (
    .clk_i(clk), .clear_i(clear_a), .stall_i(stall_a), .stall_mask_i(mask_a),
    .div_i(div_a), .step_mode_i(step_mode_a), .step_req_i(step_req_a),
    .phi_o(phi_a), .cycle_start_o(cs_a), .stalled_o(stalled_a), .step_ack_o(ack_a),
    .clk_o(clk_oa), .clear_o(clear_oa)
  );

  cmu_phase_seq #(.NPHASE(4), .DIV_W(4), .NSTALL(2)) u_dut_b (
    .clk_i(clk), .clear_i(clear_b), .stall_i(stall_b), .stall_mask_i(mask_b),
    .div_i(div_b), .step_mode_i(step_mode_b), .step_req_i(step_req_b),
    .phi_o(phi_b), .cycle_start_o(cs_b), .stalled_o(stalled_b), .step_ack_o(ack_b),
    .clk_o(clk_ob), .clear_o(clear_ob)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic push_evt(input bit b, input int c, input logic [3:0] phi, input logic cs, input logic ack);
    evt_t e;
    e.cyc = c;
    e.phi = phi;
    e.cs  = cs;
    e.ack = ack;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  // One machine cycle: cycle_start at s, phase i pulses at s + i*l + l - 1.
  task automatic push_cycle(input bit b, input int s, input int l, input int np, input bit ack);
    logic [3:0] one;
    one = 4'b0001;
    push_evt(b, s, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < np; i++)
      push_evt(b, s + i * l + l - 1, one << i, 1'b0, ack && (i == np - 1));
  endtask

  task automatic mon(input bit b, input int c, input logic [3:0] phi, input logic cs, input logic ack);
    evt_t  e;
    string p;
    int    sz;
    p  = b ? "b" : "a";
    sz = b ? qb.size() : qa.size();
    if (phi != 4'b0000 || cs || ack) begin
      if (sz == 0) begin
        check_eq({p, "_unexpected_evt"}, {26'd0, cs, ack, phi}, 32'd0);
      end else begin
        if (b) e = qb.pop_front();
        else   e = qa.pop_front();
        check_eq({p, "_evt_cyc"}, c, e.cyc);
        check_eq({p, "_evt_val"}, {26'd0, cs, ack, phi}, {26'd0, e.cs, e.ack, e.phi});
      end
    end
  endtask

  always @(negedge clk) if (!done) mon(1'b0, cyc, {2'b00, phi_a}, cs_a, ack_a);
  always @(negedge clk) if (!done) mon(1'b1, cyc, phi_b, cs_b, ack_b);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2, s3, sb;
`ifdef CMU_STEP_EN
    int t, u;
`endif
    tick(3);
    check_eq("a_rst_phi", phi_a, 0);
    check_eq("a_rst_cs", cs_a, 0);
    check_eq("a_rst_stalled", stalled_a, 0);
    check_eq("a_rst_ack", ack_a, 0);
    check_eq("a_clear_pass", clear_oa, 1);
    check_eq("a_clk_pass", clk_oa, clk);

    // Free run, div 0: cycle_start then phi 01 / 10, period 4
    clear_a = 1'b0;
    #1;
    check_eq("a_rel_cs", cs_a, 0);
    check_eq("a_rel_phi", phi_a, 0);
    check_eq("a_clear_pass_lo", clear_oa, 0);
    s = cyc + 1;
    push_cycle(1'b0, s, 2, 2, 1'b0);
    push_cycle(1'b0, s + 4, 2, 2, 1'b0);
    push_cycle(1'b0, s + 8, 2, 2, 1'b0);

    // Unmasked stall mid-cycle: cycle completes, then hold
    wait_cyc(s + 9);
    stall_a = 2'b01;
    wait_cyc(s + 12);
    check_eq("a_stalled_1", stalled_a, 1);
    check_eq("a_stall_phi", phi_a, 0);
    wait_cyc(s + 13);
    check_eq("a_stalled_2", stalled_a, 1);
    stall_a = 2'b00;
    s2 = s + 14;
    push_cycle(1'b0, s2, 2, 2, 1'b0);
    push_cycle(1'b0, s2 + 4, 2, 2, 1'b0);

    // Masked stall ignored; div change takes effect at next cycle start
    wait_cyc(s2 + 1);
    stall_a = 2'b10;
    mask_a  = 2'b10;
    wait_cyc(s2 + 5);
    div_a = 4'd2;
    push_cycle(1'b0, s2 + 8, 4, 2, 1'b0);
    push_evt(1'b0, s2 + 16, 4'b0000, 1'b1, 1'b0);
    wait_cyc(s2 + 9);
    check_eq("a_masked_stalled", stalled_a, 0);

    // clear during phi[0] gates it in the same clock
    wait_cyc(s2 + 19);
    clear_a = 1'b1;
    #1;
    check_eq("a_clr_gate_phi", phi_a, 0);
    check_eq("a_clr_gate_cs", cs_a, 0);
    wait_cyc(s2 + 21);
    check_eq("a_clr_phi", phi_a, 0);
    check_eq("a_clr_stalled", stalled_a, 0);
    check_eq("a_clr_ack", ack_a, 0);
    clear_a = 1'b0;
    div_a   = 4'd1;
    #1;
    check_eq("a_rel2_phi", phi_a, 0);
    check_eq("a_rel2_cs", cs_a, 0);
    check_eq("a_rel2_stalled", stalled_a, 0);
    s3 = s2 + 22;
    push_cycle(1'b0, s3, 3, 2, 1'b0);
    push_cycle(1'b0, s3 + 6, 3, 2, 1'b0);

`ifdef CMU_STEP_EN
    // Step mode: park at cycle end, one cycle per request
    wait_cyc(s3 + 7);
    step_mode_a = 1'b1;
    wait_cyc(s3 + 13);
    check_eq("a_step_idle_stalled", stalled_a, 0);
    check_eq("a_step_idle_q", qa.size(), 0);
    t = s3 + 14;
    wait_cyc(t);
    step_req_a = 1'b1;
    push_cycle(1'b0, t + 2, 3, 2, 1'b1);
    tick(1);
    step_req_a = 1'b0;

    // Two requests inside one step cycle give one extra cycle only
    u = t + 10;
    wait_cyc(u);
    step_req_a = 1'b1;
    push_cycle(1'b0, u + 2, 3, 2, 1'b1);
    push_cycle(1'b0, u + 8, 3, 2, 1'b1);
    tick(1);
    step_req_a = 1'b0;
    wait_cyc(u + 3);
    step_req_a = 1'b1;
    tick(1);
    step_req_a = 1'b0;
    wait_cyc(u + 5);
    step_req_a = 1'b1;
    tick(1);
    step_req_a = 1'b0;
    wait_cyc(u + 18);
    check_eq("a_step_end_stalled", stalled_a, 0);
`else
    // Step inputs have no effect; stop the run with an unmasked stall
    wait_cyc(s3 + 7);
    step_mode_a = 1'b1;
    step_req_a  = 1'b1;
    push_cycle(1'b0, s3 + 12, 3, 2, 1'b0);
    push_cycle(1'b0, s3 + 18, 3, 2, 1'b0);
    tick(1);
    step_req_a = 1'b0;
    wait_cyc(s3 + 19);
    stall_a = 2'b01;
    mask_a  = 2'b00;
    wait_cyc(s3 + 25);
    check_eq("a_nostep_stalled", stalled_a, 1);
    wait_cyc(s3 + 27);
`endif
    check_eq("a_q_empty", qa.size(), 0);

    // Four phases, div 1: 12-clock period, then div max
    clear_b = 1'b0;
    div_b   = 4'd1;
    sb = cyc + 1;
    push_cycle(1'b1, sb, 3, 4, 1'b0);
    push_cycle(1'b1, sb + 12, 3, 4, 1'b0);
    push_cycle(1'b1, sb + 24, 3, 4, 1'b0);
    wait_cyc(sb + 25);
    div_b = 4'hF;
    push_cycle(1'b1, sb + 36, 17, 4, 1'b0);
    wait_cyc(sb + 37);
    stall_b = 2'b01;
    wait_cyc(sb + 106);
    check_eq("b_stalled", stalled_b, 1);
    check_eq("b_ack", ack_b, 0);
    check_eq("b_q_empty", qb.size(), 0);

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
